// File: rtl/dl_pkg.sv
// Shared helpers for the delay line: a constant clog2 used to size the tap select,
// and a popcount used to turn the stage valid bits into the fill level.
package dl_pkg;

   localparam int POP_MAX = 64;

   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

   function automatic int unsigned popcount(input logic [POP_MAX-1:0] bits);
      int unsigned cnt;
      cnt = 0;
      for (int i = 0; i < POP_MAX; i++) begin
         cnt = cnt + int'(bits[i]);
      end
      return cnt;
   endfunction

endpackage

// File: rtl/delay_stage.sv
// One {valid, data} register of the delay line. clr_i drops the valid bit and
// leaves the data unchanged, so a flush does not toggle the data flops.
module delay_stage #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic             clr_i,
   input  logic             v_i,
   input  logic [WIDTH-1:0] d_i,
   output logic             v_o,
   output logic [WIDTH-1:0] d_o
);

   logic             v_q, v_d;
   logic [WIDTH-1:0] d_q, d_d;

   always_comb begin
      v_d = v_q;
      d_d = d_q;
      if (clr_i) begin
         v_d = 1'b0;
      end else if (en_i) begin
         v_d = v_i;
         d_d = d_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         v_q <= 1'b0;
         d_q <= '0;
      end else begin
         v_q <= v_d;
         d_q <= d_d;
      end
   end

   assign v_o = v_q;
   assign d_o = d_q;

endmodule

// File: rtl/delay_line_pipe.sv
// Delay line of DEPTH {valid, data} stages with a run-time output tap (0 = bypass),
// global advance enable, flush of all valid bits, and a registered fill level.
module delay_line_pipe
   import dl_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int SELW  = clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic             flush_i,
   input  logic [SELW-1:0]  sel_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             valid_i,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o,
   output logic [SELW-1:0]  fill_o
);

   typedef struct packed {
      logic             v;
      logic [WIDTH-1:0] d;
   } stage_t;

   // valid_i only qualifies data_i; there is no backpressure, words shift on en_i alone.
   // Index 0 is the live input, index k is the output of stage k.
   logic [DEPTH:0]   chain_v;
   logic [WIDTH-1:0] chain_d [0:DEPTH];

   assign chain_v[0] = valid_i;
   assign chain_d[0] = data_i;

   for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
      delay_stage #(
         .WIDTH (WIDTH)
      ) u_stage (
         .clk_i  (clk_i),
         .rst_ni (rst_ni),
         .en_i   (en_i),
         .clr_i  (flush_i),
         .v_i    (chain_v[k-1]),
         .d_i    (chain_d[k-1]),
         .v_o    (chain_v[k]),
         .d_o    (chain_d[k])
      );
   end

   logic [SELW-1:0] sel_eff;
   stage_t          tap;

   always_comb begin
      sel_eff = sel_i;
      if (sel_i > SELW'(DEPTH)) begin
         sel_eff = SELW'(DEPTH);
      end
      tap.v = chain_v[sel_eff];
      tap.d = chain_d[sel_eff];
   end

   assign data_o  = tap.d;
   assign valid_o = tap.v;

   // Fill is computed from the stage valids as they will be after this edge,
   // so fill_o lines up with the stages instead of trailing them by a cycle.
   logic [DEPTH-1:0]   nxt_v;
   logic [POP_MAX-1:0] pop_vec;
   logic [SELW-1:0]    fill_q, fill_d;

   always_comb begin
      nxt_v = chain_v[DEPTH:1];
      if (flush_i) begin
         nxt_v = '0;
      end else if (en_i) begin
         nxt_v = chain_v[DEPTH-1:0];
      end
      pop_vec              = '0;
      pop_vec[DEPTH-1:0]   = nxt_v;
      fill_d               = SELW'(popcount(pop_vec));
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fill_q <= '0;
      end else begin
         fill_q <= fill_d;
      end
   end

   assign fill_o = fill_q;

endmodule
